dot_frame_source: RTL

//  Double-buffered 8x8 frame store with horizontal scroll. Sits directly upstream of the
//  dot-matrix row scanner: the scanner strobes a row index each scan step and receives that
//  row's column bits one cycle later. Writers fill the back bank row by row; banks swap only
//  at a frame boundary, so the panel never shows a half-written image.

---
 rtl/dot_frame_source.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dot_frame_source.sv
// Double-buffered row store feeding the dot-matrix scanner, with per-frame horizontal scroll.
// Read latency 1 cycle; wr_ready drops from an accepted wr_last until the next frame boundary swaps banks.
module dot_frame_source #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int SCROLL_DIV = 16,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [RW-1:0]   wr_row,
    input  logic [COLS-1:0] wr_data,
    input  logic            wr_last,
    input  logic            scroll_en,
    input  logic            rd_en,
    input  logic [RW-1:0]   rd_row,
    output logic [COLS-1:0] rd_data,
    output logic            frame_tick,
    output logic            swap_pending
);
    localparam int OW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [OW-1:0] LAST_OFS = OW'(COLS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SCROLL_DIV - 1);

    logic [COLS-1:0] bank_q [2][ROWS];
    logic [COLS-1:0] bank_d [2][ROWS];
    logic            front_q, front_d;
    logic            swap_pending_q, swap_pending_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [COLS-1:0] rd_data_q, rd_data_d;
    logic            frame_tick_q, frame_tick_d;

    logic            wr_fire;
    logic            boundary;
    logic [COLS-1:0] row_sel;
    logic [COLS-1:0] row_rot;

    always_comb begin
        bank_d         = bank_q;
        front_d        = front_q;
        swap_pending_d = swap_pending_q;
        offset_d       = offset_q;
        frame_cnt_d    = frame_cnt_q;
        rd_data_d      = rd_data_q;
        frame_tick_d   = 1'b0;
        row_sel        = '0;

        wr_fire  = wr_valid && !swap_pending_q;
        boundary = rd_en && (rd_row == LAST_ROW);

        // Rotate toward bit 0: output column c shows stored column (c+offset) mod COLS.
        if (int'(rd_row) < ROWS) begin
            row_sel = bank_q[front_q][rd_row];
        end
        row_rot = (row_sel >> offset_q) | (row_sel << (COLS - int'(offset_q)));

        if (rd_en) begin
            rd_data_d = row_rot;
        end
        frame_tick_d = boundary;

        if (wr_fire && (int'(wr_row) < ROWS)) begin
            bank_d[~front_q][wr_row] = wr_data;
        end
        if (wr_fire && wr_last) begin
            swap_pending_d = 1'b1;
        end

        // A swap pending before this boundary wins over scrolling and restarts the scroll.
        if (boundary) begin
            if (swap_pending_q) begin
                front_d        = ~front_q;
                swap_pending_d = 1'b0;
                offset_d       = '0;
                frame_cnt_d    = '0;
            end else if (scroll_en) begin
                if (frame_cnt_q == LAST_CNT) begin
                    frame_cnt_d = '0;
                    offset_d    = (offset_q == LAST_OFS) ? '0 : offset_q + 1'b1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    bank_q[b][r] <= '0;
                end
            end
            front_q        <= 1'b0;
            swap_pending_q <= 1'b0;
            offset_q       <= '0;
            frame_cnt_q    <= '0;
            rd_data_q      <= '0;
            frame_tick_q   <= 1'b0;
        end else begin
            bank_q         <= bank_d;
            front_q        <= front_d;
            swap_pending_q <= swap_pending_d;
            offset_q       <= offset_d;
            frame_cnt_q    <= frame_cnt_d;
            rd_data_q      <= rd_data_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign wr_ready     = ~swap_pending_q;
    assign swap_pending = swap_pending_q;
    assign rd_data      = rd_data_q;
    assign frame_tick   = frame_tick_q;

endmodule
